// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit CPU control unit.
// Holds opcode values, alu_load_src codes, instruction field positions with
// slice helpers, the control FSM state enum and the control-bundle struct
// that the decoder hands to control_fsm.
package cpu_pkg;

    // Opcodes (instruction bits [15:12]); 0x0-0x7 are ALU reg-reg operations.
    localparam logic [3:0] OpAddi  = 4'h8;
    localparam logic [3:0] OpLoadi = 4'h9;
    localparam logic [3:0] OpLoad  = 4'hA;
    localparam logic [3:0] OpStore = 4'hB;
    localparam logic [3:0] OpJmp   = 4'hC;
    localparam logic [3:0] OpBr    = 4'hD;
    localparam logic [3:0] OpPlot  = 4'hE;
    localparam logic [3:0] OpHalt  = 4'hF;

    // alu_load_src codes: which value the datapath writes into the register file.
    localparam logic [1:0] LoadSrcNone = 2'b00;
    localparam logic [1:0] LoadSrcAlu  = 2'b01;
    localparam logic [1:0] LoadSrcMem  = 2'b10;

    // Branch condition selects (rb[1:0] of a BR instruction).
    localparam logic [1:0] BrZero   = 2'b00;
    localparam logic [1:0] BrSign   = 2'b01;
    localparam logic [1:0] BrOvf    = 2'b10;
    localparam logic [1:0] BrAlways = 2'b11;

    // Instruction field positions.
    localparam int unsigned OpMsb = 15;
    localparam int unsigned OpLsb = 12;
    localparam int unsigned RdMsb = 11;
    localparam int unsigned RdLsb = 8;
    localparam int unsigned RaMsb = 7;
    localparam int unsigned RaLsb = 4;
    localparam int unsigned RbMsb = 3;
    localparam int unsigned RbLsb = 0;

    typedef enum logic [2:0] {
        StFetch,
        StExec,
        StMem,
        StImmW,
        StImm,
        StPlot,
        StHalt,
        StError
    } state_e;

    // One cycle's worth of datapath controls.
    typedef struct packed {
        logic        pc_inc;
        logic [3:0]  alu_op;
        logic [3:0]  a_select;
        logic [3:0]  b_select;
        logic [3:0]  out_select;
        logic [15:0] a_altern;
        logic [15:0] b_altern;
        logic        a_source;
        logic        b_source;
        logic [1:0]  load_src;
        logic        store_mem;
        logic        store_stk;
        logic [3:0]  color_select;
        logic [3:0]  coord_select;
        logic        vga_plot;
        logic        halted;
    } ctrl_t;

    function automatic logic [3:0] get_op(input logic [15:0] instr);
        return instr[OpMsb:OpLsb];
    endfunction

    function automatic logic [3:0] get_rd(input logic [15:0] instr);
        return instr[RdMsb:RdLsb];
    endfunction

    function automatic logic [3:0] get_ra(input logic [15:0] instr);
        return instr[RaMsb:RaLsb];
    endfunction

    function automatic logic [3:0] get_rb(input logic [15:0] instr);
        return instr[RbMsb:RbLsb];
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// control_fsm_if: bundle between control_fsm, the datapath and the VGA plotter.
// Ports carried:
//   current_instruction     : memory word at PC (datapath -> control)
//   signflag/zeroflag/overflow/errorbit : datapath flags, bit 0 meaningful
//   vga_ready               : plotter can accept a pixel
//   program_counter_increment, alu_*, vga_*_select : datapath controls
//   vga_plot                : pixel request to the plotter
//   halted                  : CPU stopped (HALT or ERROR)
// Modports: master = control unit side, slave = datapath/plotter side.
interface control_fsm_if;

    logic [15:0] current_instruction;
    logic [15:0] signflag;
    logic [15:0] zeroflag;
    logic [15:0] overflow;
    logic [15:0] errorbit;
    logic        vga_ready;

    logic        program_counter_increment;
    logic [3:0]  alu_op;
    logic [3:0]  alu_a_select;
    logic [3:0]  alu_b_select;
    logic [3:0]  alu_out_select;
    logic [15:0] alu_a_altern;
    logic [15:0] alu_b_altern;
    logic        alu_a_source;
    logic        alu_b_source;
    logic [1:0]  alu_load_src;
    logic        alu_store_to_mem;
    logic        alu_store_to_stk;
    logic [3:0]  vga_color_select;
    logic [3:0]  vga_coord_select;
    logic        vga_plot;
    logic        halted;

    modport master (
        input  current_instruction, signflag, zeroflag, overflow, errorbit, vga_ready,
        output program_counter_increment, alu_op, alu_a_select, alu_b_select,
               alu_out_select, alu_a_altern, alu_b_altern, alu_a_source, alu_b_source,
               alu_load_src, alu_store_to_mem, alu_store_to_stk, vga_color_select,
               vga_coord_select, vga_plot, halted
    );

    modport slave (
        output current_instruction, signflag, zeroflag, overflow, errorbit, vga_ready,
        input  program_counter_increment, alu_op, alu_a_select, alu_b_select,
               alu_out_select, alu_a_altern, alu_b_altern, alu_a_source, alu_b_source,
               alu_load_src, alu_store_to_mem, alu_store_to_stk, vga_color_select,
               vga_coord_select, vga_plot, halted
    );

endinterface

// File: rtl/instr_decode.sv
// instr_decode: combinational instruction-register decoder.
// Produces the control bundle driven while an instruction is in EXEC.
// Ports:
//   ir        : latched instruction word
//   zero_flag, sign_flag, ovf_flag : datapath flag bits for BR conditions
//   exec_ctrl : decoded controls for the EXEC cycle
module instr_decode
    import cpu_pkg::*;
#(
    parameter int unsigned IMM_W = 4
) (
    input  logic [15:0] ir,
    input  logic        zero_flag,
    input  logic        sign_flag,
    input  logic        ovf_flag,
    output ctrl_t       exec_ctrl
);

    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [3:0] rb;
    logic       br_cond;

    assign op = get_op(ir);
    assign rd = get_rd(ir);
    assign ra = get_ra(ir);
    assign rb = get_rb(ir);

    always_comb begin
        br_cond = 1'b1;
        case (rb[1:0])
            BrZero:   br_cond = zero_flag;
            BrSign:   br_cond = sign_flag;
            BrOvf:    br_cond = ovf_flag;
            BrAlways: br_cond = 1'b1;
            default:  br_cond = 1'b1;
        endcase
    end

    always_comb begin
        exec_ctrl        = '0;
        exec_ctrl.pc_inc = 1'b1;
        if (!op[3]) begin
            // ALU reg-reg: opcode low bits select the operation.
            exec_ctrl.alu_op     = {1'b0, op[2:0]};
            exec_ctrl.a_select   = ra;
            exec_ctrl.b_select   = rb;
            exec_ctrl.out_select = rd;
            exec_ctrl.load_src   = LoadSrcAlu;
        end else begin
            case (op)
                OpAddi: begin
                    exec_ctrl.alu_op                 = 4'd1;
                    exec_ctrl.a_select               = ra;
                    exec_ctrl.b_source               = 1'b1;
                    exec_ctrl.b_altern[IMM_W-1:0]    = ir[IMM_W-1:0];
                    exec_ctrl.out_select             = rd;
                    exec_ctrl.load_src               = LoadSrcAlu;
                end
                OpLoad: begin
                    exec_ctrl.a_select   = ra;
                    exec_ctrl.out_select = rd;
                    exec_ctrl.load_src   = LoadSrcMem;
                end
                OpStore: begin
                    exec_ctrl.a_select   = ra;
                    exec_ctrl.out_select = rd;
                    exec_ctrl.store_mem  = 1'b1;
                end
                OpJmp: begin
                    // ALU passes ra through and the result is written to PC (r0).
                    exec_ctrl.a_select = ra;
                    exec_ctrl.load_src = LoadSrcAlu;
                    exec_ctrl.pc_inc   = 1'b0;
                end
                OpBr: begin
                    if (br_cond) begin
                        exec_ctrl.a_select = ra;
                        exec_ctrl.load_src = LoadSrcAlu;
                        exec_ctrl.pc_inc   = 1'b0;
                    end
                end
                OpPlot: begin
                    // PC advances once, at the end of the plot handshake.
                    exec_ctrl.color_select = rd;
                    exec_ctrl.coord_select = ra;
                    exec_ctrl.pc_inc       = 1'b0;
                end
                default: begin
                    // LOADI and HALT only step PC here.
                end
            endcase
        end
    end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit for the 16-bit CPU.
// Holds the state and instruction registers, sequences multi-cycle
// instructions (LOAD, LOADI, PLOT) and overrides the decoded controls per state.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : control_fsm_if master modport (instruction, flags, vga_ready in;
//           all datapath controls, vga_plot and halted out)
module control_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned IMM_W = 4
) (
    input logic            clock,
    input logic            reset,
    control_fsm_if.master  bus
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       exec_ctrl;
    ctrl_t       ctrl;
    logic        unused_flags;

    // Only bit 0 of each flag word is meaningful.
    assign unused_flags = ^{bus.signflag[15:1], bus.zeroflag[15:1], bus.overflow[15:1],
                            bus.errorbit[15:1]};

    instr_decode #(
        .IMM_W (IMM_W)
    ) u_instr_decode (
        .ir        (ir_q),
        .zero_flag (bus.zeroflag[0]),
        .sign_flag (bus.signflag[0]),
        .ovf_flag  (bus.overflow[0]),
        .exec_ctrl (exec_ctrl)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign ir_d = (state_q == StFetch) ? bus.current_instruction : ir_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch: state_d = StExec;
            StExec: begin
                case (get_op(ir_q))
                    OpLoad:  state_d = StMem;
                    OpLoadi: state_d = StImmW;
                    OpPlot:  state_d = StPlot;
                    OpHalt:  state_d = StHalt;
                    default: state_d = StFetch;
                endcase
            end
            StMem:   state_d = StFetch;
            StImmW:  state_d = StImm;
            StImm:   state_d = StFetch;
            StPlot:  state_d = bus.vga_ready ? StFetch : StPlot;
            StHalt:  state_d = StHalt;
            StError: state_d = StError;
            default: state_d = StError;
        endcase
        // A sampled error beats every other transition, so e.g. a LOAD never
        // reaches its MEM cycle once the error is seen in EXEC.
        if (bus.errorbit[0]) begin
            state_d = StError;
        end
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            StExec: ctrl = exec_ctrl;
            StMem: begin
                ctrl        = exec_ctrl;
                ctrl.pc_inc = 1'b0;
            end
            StImm: begin
                // Second LOADI word is on the bus this cycle; route it straight in.
                ctrl.a_source   = 1'b1;
                ctrl.a_altern   = bus.current_instruction;
                ctrl.out_select = get_rd(ir_q);
                ctrl.load_src   = LoadSrcAlu;
                ctrl.pc_inc     = 1'b1;
            end
            StPlot: begin
                ctrl.color_select = get_rd(ir_q);
                ctrl.coord_select = get_ra(ir_q);
                ctrl.vga_plot     = 1'b1;
                ctrl.pc_inc       = bus.vga_ready;
            end
            StHalt, StError: ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
        ctrl.store_stk = 1'b0;
    end

    assign bus.program_counter_increment = ctrl.pc_inc;
    assign bus.alu_op                    = ctrl.alu_op;
    assign bus.alu_a_select              = ctrl.a_select;
    assign bus.alu_b_select              = ctrl.b_select;
    assign bus.alu_out_select            = ctrl.out_select;
    assign bus.alu_a_altern              = ctrl.a_altern;
    assign bus.alu_b_altern              = ctrl.b_altern;
    assign bus.alu_a_source              = ctrl.a_source;
    assign bus.alu_b_source              = ctrl.b_source;
    assign bus.alu_load_src              = ctrl.load_src;
    assign bus.alu_store_to_mem          = ctrl.store_mem;
    assign bus.alu_store_to_stk          = ctrl.store_stk;
    assign bus.vga_color_select          = ctrl.color_select;
    assign bus.vga_coord_select          = ctrl.coord_select;
    assign bus.vga_plot                  = ctrl.vga_plot;
    assign bus.halted                    = ctrl.halted;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: self-checking bench for control_fsm.
// Each instruction is expanded into its expected per-cycle control sequence
// and compared against the DUT outputs on the falling clock edge.
module tb_control_fsm;

    typedef struct packed {
        logic        pc_inc;
        logic [3:0]  alu_op;
        logic [3:0]  a_sel;
        logic [3:0]  b_sel;
        logic [3:0]  out_sel;
        logic [15:0] a_alt;
        logic [15:0] b_alt;
        logic        a_src;
        logic        b_src;
        logic [1:0]  load_src;
        logic        st_mem;
        logic        st_stk;
        logic [3:0]  color;
        logic [3:0]  coord;
        logic        plot;
        logic        halted;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    control_fsm_if bus ();

    control_fsm #(
        .IMM_W (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic exp_t observe();
        exp_t o;
        o.pc_inc   = bus.program_counter_increment;
        o.alu_op   = bus.alu_op;
        o.a_sel    = bus.alu_a_select;
        o.b_sel    = bus.alu_b_select;
        o.out_sel  = bus.alu_out_select;
        o.a_alt    = bus.alu_a_altern;
        o.b_alt    = bus.alu_b_altern;
        o.a_src    = bus.alu_a_source;
        o.b_src    = bus.alu_b_source;
        o.load_src = bus.alu_load_src;
        o.st_mem   = bus.alu_store_to_mem;
        o.st_stk   = bus.alu_store_to_stk;
        o.color    = bus.vga_color_select;
        o.coord    = bus.vga_coord_select;
        o.plot     = bus.vga_plot;
        o.halted   = bus.halted;
        return o;
    endfunction

    task automatic compare(input string tag, input exp_t exp);
        exp_t obs;
        obs = observe();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare during the current cycle, then move to just after the next edge.
    task automatic check(input string tag, input exp_t exp);
        @(negedge clock);
        compare(tag, exp);
        @(posedge clock);
        #1;
    endtask

    // Controls the EXEC cycle must drive for an instruction word.
    function automatic exp_t exec_exp(input logic [15:0] w, input logic zf, input logic sf,
                                      input logic of);
        exp_t       e;
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       cond;
        e  = '0;
        op = w[15:12];
        rd = w[11:8];
        ra = w[7:4];
        rb = w[3:0];
        e.pc_inc = 1'b1;
        if (op < 4'd8) begin
            e.alu_op   = {1'b0, op[2:0]};
            e.a_sel    = ra;
            e.b_sel    = rb;
            e.out_sel  = rd;
            e.load_src = 2'b01;
        end else if (op == 4'h8) begin
            e.alu_op   = 4'd1;
            e.a_sel    = ra;
            e.b_src    = 1'b1;
            e.b_alt    = {12'h000, rb};
            e.out_sel  = rd;
            e.load_src = 2'b01;
        end else if (op == 4'hA) begin
            e.a_sel    = ra;
            e.out_sel  = rd;
            e.load_src = 2'b10;
        end else if (op == 4'hB) begin
            e.a_sel   = ra;
            e.out_sel = rd;
            e.st_mem  = 1'b1;
        end else if (op == 4'hC || op == 4'hD) begin
            if (op == 4'hC)        cond = 1'b1;
            else if (rb[1:0] == 0) cond = zf;
            else if (rb[1:0] == 1) cond = sf;
            else if (rb[1:0] == 2) cond = of;
            else                   cond = 1'b1;
            if (cond) begin
                e.a_sel    = ra;
                e.load_src = 2'b01;
                e.pc_inc   = 1'b0;
            end
        end else if (op == 4'hE) begin
            e.color  = rd;
            e.coord  = ra;
            e.pc_inc = 1'b0;
        end
        return e;
    endfunction

    // Drive one instruction through its full expected cycle sequence.
    task automatic run_instr(input logic [15:0] w, input logic [15:0] second,
                             input int nlow);
        exp_t e;
        exp_t m;
        bus.current_instruction = w;
        check("fetch", '0);
        e = exec_exp(w, bus.zeroflag[0], bus.signflag[0], bus.overflow[0]);
        check("exec", e);
        if (w[15:12] == 4'hA) begin
            m        = e;
            m.pc_inc = 1'b0;
            check("mem", m);
        end else if (w[15:12] == 4'h9) begin
            bus.current_instruction = second;
            check("immw", '0);
            m          = '0;
            m.a_src    = 1'b1;
            m.a_alt    = second;
            m.out_sel  = w[11:8];
            m.load_src = 2'b01;
            m.pc_inc   = 1'b1;
            check("imm", m);
        end else if (w[15:12] == 4'hE) begin
            for (int k = 0; k <= nlow; k++) begin
                bus.vga_ready = (k == nlow);
                m        = '0;
                m.color  = w[11:8];
                m.coord  = w[7:4];
                m.plot   = 1'b1;
                m.pc_inc = (k == nlow);
                check("plot", m);
            end
        end
    endtask

    task automatic do_reset();
        exp_t h;
        h = '0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) check("reset", h);
        reset = 1'b0;
    endtask

    initial begin
        exp_t h;
        exp_t idle;
        logic [15:0] w;
        h        = '0;
        h.halted = 1'b1;
        idle     = '0;

        bus.current_instruction = 16'h0000;
        bus.signflag            = 16'h0000;
        bus.zeroflag            = 16'h0000;
        bus.overflow            = 16'h0000;
        bus.errorbit            = 16'h0000;
        bus.vga_ready           = 1'b0;
        #1;
        do_reset();

        // Directed cases.
        run_instr(16'h8702, 16'h0000, 0);
        run_instr(16'h9600, 16'hBEEF, 0);
        bus.zeroflag = 16'h0001;
        run_instr(16'hD070, 16'h0000, 0);
        bus.zeroflag = 16'hFFFE;
        run_instr(16'hD070, 16'h0000, 0);
        run_instr(16'hE320, 16'h0000, 3);
        run_instr(16'hE320, 16'h0000, 0);
        run_instr(16'h0000, 16'h0000, 0);

        // Randomized instruction stream (no HALT; errorbit bit 0 kept low).
        for (int n = 0; n < 250; n++) begin
            w             = {4'($urandom_range(0, 14)), 12'($urandom)};
            bus.signflag  = 16'($urandom);
            bus.zeroflag  = 16'($urandom);
            bus.overflow  = 16'($urandom);
            bus.errorbit  = 16'($urandom) & 16'hFFFE;
            bus.vga_ready = 1'($urandom);
            run_instr(w, 16'($urandom), $urandom_range(0, 3));
        end
        bus.errorbit = 16'h0000;

        // HALT: stays halted with idle controls until reset.
        run_instr(16'hF000, 16'h0000, 0);
        for (int k = 0; k < 4; k++) check("halt", h);
        do_reset();
        run_instr(16'h1234, 16'h0000, 0);

        // Error raised during a LOAD's EXEC: no MEM cycle follows.
        bus.current_instruction = 16'hA350;
        check("err_fetch", idle);
        bus.errorbit = 16'h0001;
        check("err_exec", exec_exp(16'hA350, 1'b0, 1'b0, 1'b0));
        bus.errorbit = 16'h0000;
        for (int k = 0; k < 4; k++) check("error", h);
        do_reset();

        // Asynchronous reset mid-LOADI aborts at once; no IMM write afterwards.
        bus.current_instruction = 16'h9400;
        check("abort_fetch", idle);
        check("abort_exec", exec_exp(16'h9400, 1'b0, 1'b0, 1'b0));
        reset = 1'b1;
        #2;
        compare("abort_async", idle);
        @(posedge clock);
        #1;
        reset = 1'b0;
        run_instr(16'h8A05, 16'h0000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
